// File: rtl/spdif_pkg.sv
// Shared constants, subframe word layout and parity helper for the S/PDIF transmitter.
package spdif_pkg;

   localparam logic [7:0] PRE_B = 8'b00010111;
   localparam logic [7:0] PRE_M = 8'b00011101;
   localparam logic [7:0] PRE_W = 8'b00011011;

   localparam int SUBFRAME_CELLS   = 64;
   localparam int FRAME_CELLS      = 128;
   localparam int FRAMES_PER_BLOCK = 192;

   typedef enum logic [1:0] {
      PRE_SEL_B,
      PRE_SEL_M,
      PRE_SEL_W
   } pre_sel_e;

   // One bit per 2-cell slot; slot 31 (P) is the MSB, slots 0..3 carry the preamble.
   typedef struct packed {
      logic        p;
      logic        c;
      logic        u;
      logic        v;
      logic [23:0] aud;
      logic [3:0]  pre;
   } sf_word_t;

   function automatic logic parity28(input logic [27:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line encoder: emits one cell per strobe from the preamble select and subframe word.
module spdif_bmc_enc
   import spdif_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cell_stb,
   input  logic [5:0] cell_idx,
   input  sf_word_t   sf_word,
   input  pre_sel_e   pre_sel,
   output logic       signal
);

   logic        sig_q, sig_d;
   logic        inv_q, inv_d;
   logic        inv;
   logic [7:0]  pre;
   logic [31:0] w;

   assign w = sf_word;

   always_comb begin
      sig_d = sig_q;
      inv_d = inv_q;
      inv   = inv_q;
      case (pre_sel)
         PRE_SEL_B: pre = PRE_B;
         PRE_SEL_M: pre = PRE_M;
         default:   pre = PRE_W;
      endcase
      if (cell_stb) begin
         if (cell_idx < 6'd8) begin
            // Preamble polarity is fixed by the line level just before its first cell.
            if (cell_idx == 6'd0) begin
               inv   = ~sig_q;
               inv_d = ~sig_q;
            end
            sig_d = pre[3'd7 - cell_idx[2:0]] ^ inv;
         end else if (!cell_idx[0]) begin
            sig_d = ~sig_q;
         end else begin
            sig_d = w[cell_idx[5:1]] ? ~sig_q : sig_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= 1'b0;
         inv_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
         inv_q <= inv_d;
      end
   end

   assign signal = sig_q;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF consumer transmitter: cell timing, frame/block counting, sample handshake and subframe assembly.
module spdif_tx
   import spdif_pkg::*;
#(
   parameter int CELL_DIV = 2,
   parameter int CS_BITS  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] lch,
   input  logic [23:0] rch,
   input  logic        sample_valid,
   output logic        sample_ack,
   output logic        underrun,
   input  logic [31:0] cs_word,
   input  logic        user_bit,
   output logic        signal
);

   localparam int         DW     = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;
   localparam logic [7:0] CS_LIM = (CS_BITS < 32) ? 8'(CS_BITS) : 8'd32;

   logic [DW-1:0] div_q, div_d;
   logic [6:0]    cell_q, cell_d;
   logic [7:0]    frame_q, frame_d;
   logic [23:0]   hl_q, hl_d;
   logic [23:0]   hr_q, hr_d;
   logic          v_q, v_d;
   logic          u_q, u_d;
   logic [31:0]   cs_q, cs_d;

   logic          stb;
   logic          left_start;
   logic          c_bit;
   sf_word_t      sf;
   pre_sel_e      pre_sel;

   always_comb begin
      stb        = (div_q == DW'(CELL_DIV - 1));
      left_start = stb && (cell_q == 7'd0);
      div_d      = stb ? '0 : div_q + 1'b1;
      cell_d     = cell_q;
      frame_d    = frame_q;
      hl_d       = hl_q;
      hr_d       = hr_q;
      v_d        = v_q;
      u_d        = u_q;
      cs_d       = cs_q;
      if (stb) begin
         cell_d = cell_q + 7'd1;
         if (cell_q == 7'(FRAME_CELLS - 1))
            frame_d = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
         if (cell_q[5:0] == 6'd0)
            u_d = user_bit;
      end
      // Both channels come from this one latch, so the right subframe never sees the ports.
      if (left_start) begin
         if (sample_valid) begin
            hl_d = lch;
            hr_d = rch;
            v_d  = 1'b0;
         end else begin
            hl_d = '0;
            hr_d = '0;
            v_d  = 1'b1;
         end
         if (frame_q == 8'd0)
            cs_d = cs_word;
      end
   end

   always_comb begin
      c_bit = 1'b0;
      if (frame_q < CS_LIM)
         c_bit = cs_q[frame_q[4:0]];
      sf     = '0;
      sf.aud = cell_q[6] ? hr_q : hl_q;
      sf.v   = v_q;
      sf.u   = u_q;
      sf.c   = c_bit;
      sf.p   = parity28({1'b0, sf.c, sf.u, sf.v, sf.aud});
      if (cell_q[6])
         pre_sel = PRE_SEL_W;
      else if (frame_q == 8'd0)
         pre_sel = PRE_SEL_B;
      else
         pre_sel = PRE_SEL_M;
   end

   assign sample_ack = left_start &  sample_valid & ~rst;
   assign underrun   = left_start & ~sample_valid & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         cell_q  <= '0;
         frame_q <= '0;
         hl_q    <= '0;
         hr_q    <= '0;
         v_q     <= 1'b0;
         u_q     <= 1'b0;
         cs_q    <= '0;
      end else begin
         div_q   <= div_d;
         cell_q  <= cell_d;
         frame_q <= frame_d;
         hl_q    <= hl_d;
         hr_q    <= hr_d;
         v_q     <= v_d;
         u_q     <= u_d;
         cs_q    <= cs_d;
      end
   end

   spdif_bmc_enc u_enc (
      .clk      (clk),
      .rst      (rst),
      .cell_stb (stb),
      .cell_idx (cell_q[5:0]),
      .sf_word  (sf),
      .pre_sel  (pre_sel),
      .signal   (signal)
   );

endmodule

// File: tb/tb_spdif_tx.sv
// Directed bench for spdif_tx: decodes the BMC line and checks preambles, fields, parity and handshake.
module tb_spdif_tx;

   localparam int CD = 2;
   localparam logic [7:0] B_PAT  = 8'b00010111;
   localparam logic [7:0] M_PAT  = 8'b00011101;
   localparam logic [7:0] W_PAT  = 8'b00011011;
   localparam logic [7:0] B_INV0 = 8'b11101000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] lch, rch;
   logic        sample_valid, user_bit;
   logic [31:0] cs_word;
   logic        sample_ack, underrun, signal;
   logic        ack3, und3, sig3;

   spdif_tx #(.CELL_DIV(CD), .CS_BITS(32)) dut (
      .clk(clk), .rst(rst), .lch(lch), .rch(rch), .sample_valid(sample_valid),
      .sample_ack(sample_ack), .underrun(underrun), .cs_word(cs_word),
      .user_bit(user_bit), .signal(signal)
   );

   spdif_tx #(.CELL_DIV(3), .CS_BITS(32)) dut3 (
      .clk(clk), .rst(rst), .lch(lch), .rch(rch), .sample_valid(sample_valid),
      .sample_ack(ack3), .underrun(und3), .cs_word(cs_word),
      .user_bit(user_bit), .signal(sig3)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic cnt_clr = 1'b1;
   int   ack_cnt, und_cnt;
   always @(negedge clk) begin
      if (cnt_clr) begin
         ack_cnt <= 0;
         und_cnt <= 0;
      end else begin
         if (sample_ack === 1'b1) ack_cnt <= ack_cnt + 1;
         if (underrun === 1'b1)   und_cnt <= und_cnt + 1;
      end
   end

   logic last_cell;

   task automatic get_cells(input int n, output logic [63:0] c, output logic a0, output logic u0);
      c  = '0;
      a0 = 1'b0;
      u0 = 1'b0;
      for (int i = 0; i < n; i++) begin
         repeat (CD - 1) @(posedge clk);
         #1;
         if (i == 0) begin
            a0 = sample_ack;
            u0 = underrun;
         end
         @(posedge clk);
         #1;
         c[i]      = signal;
         last_cell = signal;
      end
   endtask

   task automatic dec(input logic [63:0] c, input logic prev, output logic [7:0] raw,
                      output logic [7:0] pre, output logic [31:0] w, output int bad);
      logic p;
      raw = '0;
      pre = '0;
      w   = '0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         raw[7-i] = c[i];
         pre[7-i] = c[i] ^ ~prev;
      end
      p = c[7];
      for (int s = 4; s < 32; s++) begin
         if (c[2*s] === p) bad++;
         w[s] = c[2*s] ^ c[2*s+1];
         p    = c[2*s+1];
      end
   endtask

   task automatic chk_sub(input string nm, input logic [63:0] c, input logic prev,
                          input logic [7:0] exp_pre, input logic [23:0] aud,
                          input logic v, input logic u, input logic cb,
                          output logic [31:0] w, output logic [7:0] raw);
      logic [7:0] pre;
      int         bad;
      dec(c, prev, raw, pre, w, bad);
      chk({nm, ".pre"}, 32'(pre), 32'(exp_pre));
      chk({nm, ".bmc"}, 32'(bad), 32'd0);
      chk({nm, ".aud"}, 32'(w[27:4]), 32'(aud));
      chk({nm, ".cuv"}, 32'(w[30:28]), 32'({cb, u, v}));
      chk({nm, ".par"}, 32'(^w[31:4]), 32'd0);
   endtask

   task automatic do_reset(input string nm);
      rst     = 1'b1;
      cnt_clr = 1'b1;
      #2;
      chk({nm, ".sig"}, 32'(signal), 32'd0);
      chk({nm, ".ack"}, 32'(sample_ack), 32'd0);
      chk({nm, ".und"}, 32'(underrun), 32'd0);
      chk({nm, ".sig3"}, 32'({ack3, und3, sig3}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst       = 1'b0;
      cnt_clr   = 1'b0;
      last_cell = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0]  c;
      logic [127:0] c3;
      logic [31:0]  w;
      logic [7:0]   raw, pre;
      logic         a0, u0, prev, prevs;
      logic [23:0]  lx, rx;
      logic         ec;
      int           bad, bad3;

      lch = '0; rch = '0; sample_valid = 1'b0; user_bit = 1'b0; cs_word = '0;
      #1;
      do_reset("rst0");

      // Idle: underrun, V=1, B inverted since line starts low.
      prev = last_cell;
      get_cells(64, c, a0, u0);
      chk_sub("idle.L", c, prev, B_PAT, 24'h0, 1'b1, 1'b0, 1'b0, w, raw);
      chk("idle.raw8", 32'(raw), 32'(B_INV0));
      chk("idle.und0", 32'(u0), 32'd1);
      chk("idle.ack0", 32'(a0), 32'd0);
      prev = last_cell;
      get_cells(64, c, a0, u0);
      chk_sub("idle.R", c, prev, W_PAT, 24'h0, 1'b1, 1'b0, 1'b0, w, raw);
      chk("idle.undcnt", 32'(und_cnt), 32'd1);
      chk("idle.ackcnt", 32'(ack_cnt), 32'd0);

      // Single-LSB sample: left parity 1, right parity 0.
      sample_valid = 1'b1; lch = 24'h000001; rch = 24'h0;
      prev = last_cell;
      get_cells(64, c, a0, u0);
      chk_sub("v1.L", c, prev, M_PAT, 24'h1, 1'b0, 1'b0, 1'b0, w, raw);
      chk("v1.ack0", 32'(a0), 32'd1);
      chk("v1.und0", 32'(u0), 32'd0);
      chk("v1.slot4", 32'(c[8] ^ c[9]), 32'd1);
      chk("v1.Lp", 32'(w[31]), 32'd1);
      prev = last_cell;
      get_cells(64, c, a0, u0);
      chk_sub("v1.R", c, prev, W_PAT, 24'h0, 1'b0, 1'b0, 1'b0, w, raw);
      chk("v1.Rp", 32'(w[31]), 32'd0);

      // Reset at cell 40 of frame 2's right subframe.
      get_cells(64, c, a0, u0);
      get_cells(40, c, a0, u0);
      do_reset("midrst");
      prev = last_cell;
      get_cells(64, c, a0, u0);
      chk_sub("post.L", c, prev, B_PAT, 24'h1, 1'b0, 1'b0, 1'b0, w, raw);
      chk("post.raw8", 32'(raw), 32'(B_INV0));
      chk("post.ack0", 32'(a0), 32'd1);

      // Full block plus one frame with channel status 5; cs_word changes mid-block.
      do_reset("rst2");
      cs_word = 32'h00000005;
      for (int f = 0; f <= 192; f++) begin
         lx = 24'hA50000 ^ 24'(f);
         rx = 24'h0F0F00 + 24'(f);
         lch = lx; rch = rx;
         user_bit = (f == 3);
         if (f == 1) cs_word = 32'hFFFFFFFA;
         ec = (f == 0) || (f == 2);
         prev = last_cell;
         get_cells(64, c, a0, u0);
         chk_sub($sformatf("f%0d.L", f), c, prev, (f == 0 || f == 192) ? B_PAT : M_PAT,
                 lx, 1'b0, (f == 3), ec, w, raw);
         rch = 24'hFFFFFF;
         lch = 24'h123456;
         prev = last_cell;
         get_cells(64, c, a0, u0);
         chk_sub($sformatf("f%0d.R", f), c, prev, W_PAT, rx, 1'b0, (f == 3), ec, w, raw);
      end
      chk("blk.ackcnt", 32'(ack_cnt), 32'd193);
      chk("blk.undcnt", 32'(und_cnt), 32'd0);

      // CELL_DIV=3 instance: changes only every third clk, 192 clks per subframe.
      do_reset("rst3");
      bad3  = 0;
      prevs = sig3;
      c3    = '0;
      for (int cyc = 1; cyc <= 384; cyc++) begin
         @(posedge clk);
         #1;
         if (sig3 !== prevs && (cyc % 3) != 0) bad3++;
         prevs = sig3;
         if ((cyc % 3) == 0) c3[cyc/3-1] = sig3;
      end
      chk("d3.offgrid", 32'(bad3), 32'd0);
      dec(c3[63:0], 1'b0, raw, pre, w, bad);
      chk("d3.raw8", 32'(raw), 32'(B_INV0));
      chk("d3.bmcL", 32'(bad), 32'd0);
      dec(c3[127:64], c3[63], raw, pre, w, bad);
      chk("d3.preR", 32'(pre), 32'(W_PAT));
      chk("d3.bmcR", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
